// File: rtl/mpi_ahb3_master_if.sv
// Request/response stream and AHB3-Lite bus signals of mpi_ahb3_master.
// The master modport is the initiator's view; slave is the environment's view.
interface mpi_ahb3_master_if #(
  parameter int PLEN = 32,
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [PLEN-1:0] req_addr;
  logic            req_we;
  logic [XLEN-1:0] req_data;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  logic            ahb3_hsel_o;
  logic            ahb3_hmastlock_o;
  logic [PLEN-1:0] ahb3_haddr_o;
  logic [XLEN-1:0] ahb3_hwdata_o;
  logic            ahb3_hwrite_o;
  logic [2:0]      ahb3_hsize_o;
  logic [2:0]      ahb3_hburst_o;
  logic [3:0]      ahb3_hprot_o;
  logic [1:0]      ahb3_htrans_o;
  logic [XLEN-1:0] ahb3_hrdata_i;
  logic            ahb3_hready_i;
  logic            ahb3_hresp_i;

  modport master (
    input  req_valid, req_addr, req_we, req_data,
    input  ahb3_hrdata_i, ahb3_hready_i, ahb3_hresp_i,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output ahb3_hsel_o, ahb3_hmastlock_o, ahb3_haddr_o, ahb3_hwdata_o,
    output ahb3_hwrite_o, ahb3_hsize_o, ahb3_hburst_o, ahb3_hprot_o, ahb3_htrans_o
  );

  modport slave (
    output req_valid, req_addr, req_we, req_data,
    output ahb3_hrdata_i, ahb3_hready_i, ahb3_hresp_i,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  ahb3_hsel_o, ahb3_hmastlock_o, ahb3_haddr_o, ahb3_hwdata_o,
    input  ahb3_hwrite_o, ahb3_hsize_o, ahb3_hburst_o, ahb3_hprot_o, ahb3_htrans_o
  );
endinterface

// File: rtl/mpi_ahb3_master.sv
// AHB3-Lite initiator: ready/valid requests become pipelined single-word
// transfers with in-order responses, ERROR handling and a wait-state timeout.
module mpi_ahb3_master #(
  parameter int PLEN    = 32,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input logic               clk,
  input logic               rst,
  mpi_ahb3_master_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR2, FLUSH} state_t;

  state_t state, state_nxt;

  // Slot A (address phase) uses _p0, slot D (data phase) uses _p1.
  logic            vld_p0, cancel_p0, we_p0;
  logic [PLEN-1:0] addr_p0;
  logic [XLEN-1:0] data_p0;
  logic            we_p1;
  logic [CW-1:0]   wait_cnt;

  logic            live_q, hwrite_q;
  logic [PLEN-1:0] haddr_q;
  logic [XLEN-1:0] hwdata_q;
  logic            rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0] rsp_data_q;

  logic hready, hresp;
  logic err1, tmo, req_ready, accept, a_move, moved_cancel;

  logic            retire, retire_err;
  logic [XLEN-1:0] retire_data;
  logic            vld_nxt, cancel_nxt, we_nxt;
  logic [PLEN-1:0] addr_nxt;
  logic [XLEN-1:0] data_nxt;

  assign hready = bus.ahb3_hready_i;
  assign hresp  = bus.ahb3_hresp_i;

  // Bus event decode shared by the FSM and the slot logic.
  assign err1         = (state == BUSY) && hresp && !hready;
  assign tmo          = (state == BUSY) && !hready && !hresp && (wait_cnt == CW'(TIMEOUT - 1));
  assign req_ready    = rst && (!vld_p0 || hready) && !err1 && !tmo;
  assign accept       = bus.req_valid && req_ready;
  assign a_move       = vld_p0 && (hready || tmo);
  assign moved_cancel = cancel_p0 || tmo;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    logic d_leave;
    d_leave   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE:    d_leave = 1'b1;
      BUSY:    d_leave = hready || tmo;
      ERR2:    d_leave = hready;
      FLUSH:   d_leave = 1'b1;
      default: d_leave = 1'b1;
    endcase
    if (err1)
      state_nxt = ERR2;
    else if (d_leave)
      state_nxt = a_move ? (moved_cancel ? FLUSH : BUSY) : IDLE;
  end

  always_comb begin
    retire      = 1'b0;
    retire_err  = 1'b0;
    retire_data = '0;
    case (state)
      BUSY: begin
        if (hready || tmo) begin
          retire     = 1'b1;
          retire_err = hresp || tmo;
          if (!we_p1 && !hresp && !tmo) retire_data = bus.ahb3_hrdata_i;
        end
      end
      ERR2: begin
        retire     = hready;
        retire_err = hready;
      end
      FLUSH: begin
        retire     = 1'b1;
        retire_err = 1'b1;
      end
      default: ;
    endcase

    vld_nxt    = vld_p0;
    cancel_nxt = cancel_p0 || (err1 && vld_p0);
    addr_nxt   = addr_p0;
    we_nxt     = we_p0;
    data_nxt   = data_p0;
    if (a_move) begin
      vld_nxt    = 1'b0;
      cancel_nxt = 1'b0;
    end
    if (accept) begin
      vld_nxt    = 1'b1;
      cancel_nxt = 1'b0;
      addr_nxt   = bus.req_addr & ~PLEN'(3);
      we_nxt     = bus.req_we;
      data_nxt   = bus.req_data;
    end
  end

  // Stage p0 -> p1 boundary: slot A control, bus address phase, responses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0      <= 1'b0;
      cancel_p0   <= 1'b0;
      wait_cnt    <= '0;
      live_q      <= 1'b0;
      hwrite_q    <= 1'b0;
      haddr_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      vld_p0    <= vld_nxt;
      cancel_p0 <= cancel_nxt;
      live_q    <= vld_nxt && !cancel_nxt;
      hwrite_q  <= vld_nxt && !cancel_nxt && we_nxt;
      haddr_q   <= (vld_nxt && !cancel_nxt) ? addr_nxt : '0;
      if (a_move && !moved_cancel) hwdata_q <= data_p0;
      if (a_move || hready || tmo)  wait_cnt <= '0;
      else if (state == BUSY)       wait_cnt <= wait_cnt + CW'(1);
      rsp_valid_q <= retire;
      rsp_err_q   <= retire_err;
      rsp_data_q  <= retire_data;
    end
  end

  // Slot payloads carry no reset; their valid flags qualify them.
  always_ff @(posedge clk) begin
    addr_p0 <= addr_nxt;
    we_p0   <= we_nxt;
    data_p0 <= data_nxt;
    if (a_move) we_p1 <= we_p0;
  end

  assign bus.req_ready        = req_ready;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_err          = rsp_err_q;
  assign bus.ahb3_hsel_o      = live_q;
  assign bus.ahb3_hmastlock_o = live_q;
  assign bus.ahb3_htrans_o    = live_q ? 2'b10 : 2'b00;
  assign bus.ahb3_haddr_o     = haddr_q;
  assign bus.ahb3_hwrite_o    = hwrite_q;
  assign bus.ahb3_hwdata_o    = hwdata_q;
  assign bus.ahb3_hsize_o     = 3'b010;
  assign bus.ahb3_hburst_o    = 3'b000;
  assign bus.ahb3_hprot_o     = 4'b0011;
endmodule

// File: tb/tb_mpi_ahb3_master.sv
// Directed bench for mpi_ahb3_master: the bench plays the AHB slave cycle by
// cycle and checks bus outputs and responses against hand-derived values.
module tb_mpi_ahb3_master;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mpi_ahb3_master_if #(.PLEN(32), .XLEN(32)) bus ();

  mpi_ahb3_master #(.PLEN(32), .XLEN(32), .TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [31:0] a, input logic w, input logic [31:0] d);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_we    = w;
    bus.req_data  = d;
  endtask

  task automatic slv(input logic rdy, input logic resp, input logic [31:0] rd);
    bus.ahb3_hready_i = rdy;
    bus.ahb3_hresp_i  = resp;
    bus.ahb3_hrdata_i = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    req(1'b0, 32'h0, 1'b0, 32'h0);
    slv(1'b1, 1'b0, 32'h0);

    // Reset state
    cyc(); cyc();
    chk("rst_htrans", 32'(bus.ahb3_htrans_o), 32'h0);
    chk("rst_hsel", 32'(bus.ahb3_hsel_o), 32'h0);
    chk("rst_hmastlock", 32'(bus.ahb3_hmastlock_o), 32'h0);
    chk("rst_hwrite", 32'(bus.ahb3_hwrite_o), 32'h0);
    chk("rst_haddr", bus.ahb3_haddr_o, 32'h0);
    chk("rst_hwdata", bus.ahb3_hwdata_o, 32'h0);
    chk("rst_hsize", 32'(bus.ahb3_hsize_o), 32'h2);
    chk("rst_hburst", 32'(bus.ahb3_hburst_o), 32'h0);
    chk("rst_hprot", 32'(bus.ahb3_hprot_o), 32'h3);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b1;
    cyc();

    // Write 0x100 then read 0x100, zero wait states
    req(1'b1, 32'h100, 1'b1, 32'hDEADBEEF); #1;
    chk("t1_ready_idle", 32'(bus.req_ready), 32'h1);
    cyc();
    req(1'b1, 32'h100, 1'b0, 32'h0); #1;
    chk("t1_w_htrans", 32'(bus.ahb3_htrans_o), 32'h2);
    chk("t1_w_haddr", bus.ahb3_haddr_o, 32'h100);
    chk("t1_w_hwrite", 32'(bus.ahb3_hwrite_o), 32'h1);
    chk("t1_w_hsel", 32'(bus.ahb3_hsel_o), 32'h1);
    chk("t1_w_hmastlock", 32'(bus.ahb3_hmastlock_o), 32'h1);
    chk("t1_ready_pipe", 32'(bus.req_ready), 32'h1);
    cyc();
    req(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("t1_r_htrans", 32'(bus.ahb3_htrans_o), 32'h2);
    chk("t1_r_haddr", bus.ahb3_haddr_o, 32'h100);
    chk("t1_r_hwrite", 32'(bus.ahb3_hwrite_o), 32'h0);
    chk("t1_hwdata", bus.ahb3_hwdata_o, 32'hDEADBEEF);
    chk("t1_rsp_early", 32'(bus.rsp_valid), 32'h0);
    cyc();
    slv(1'b1, 1'b0, 32'hDEADBEEF); #1;
    chk("t1_w_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_w_rsp_err", 32'(bus.rsp_err), 32'h0);
    chk("t1_w_rsp_data", bus.rsp_data, 32'h0);
    chk("t1_idle_htrans", 32'(bus.ahb3_htrans_o), 32'h0);
    cyc();
    slv(1'b1, 1'b0, 32'h0); #1;
    chk("t1_r_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_r_rsp_data", bus.rsp_data, 32'hDEADBEEF);
    chk("t1_r_rsp_err", 32'(bus.rsp_err), 32'h0);
    cyc();
    chk("t1_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // Four back-to-back reads 0x0..0xC
    for (int k = 0; k < 8; k++) begin
      if (k < 4) req(1'b1, 32'(4 * k), 1'b0, 32'h0);
      else       req(1'b0, 32'h0, 1'b0, 32'h0);
      if (k >= 2 && k <= 5) slv(1'b1, 1'b0, 32'hA0 + 32'(k - 2));
      else                  slv(1'b1, 1'b0, 32'h0);
      #1;
      chk($sformatf("t2_htrans_k%0d", k), 32'(bus.ahb3_htrans_o),
          (k >= 1 && k <= 4) ? 32'h2 : 32'h0);
      if (k >= 1 && k <= 4)
        chk($sformatf("t2_haddr_k%0d", k), bus.ahb3_haddr_o, 32'(4 * (k - 1)));
      chk($sformatf("t2_rsp_valid_k%0d", k), 32'(bus.rsp_valid),
          (k >= 3 && k <= 6) ? 32'h1 : 32'h0);
      if (k >= 3 && k <= 6)
        chk($sformatf("t2_rsp_data_k%0d", k), bus.rsp_data, 32'hA0 + 32'(k - 3));
      cyc();
    end

    // Two wait states on read 0x10 with read 0x14 queued
    req(1'b1, 32'h10, 1'b0, 32'h0); #1;
    cyc();
    req(1'b1, 32'h14, 1'b0, 32'h0); #1;
    chk("t3_haddr_a", bus.ahb3_haddr_o, 32'h10);
    cyc();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    slv(1'b0, 1'b0, 32'h0); #1;
    chk("t3_w1_ready", 32'(bus.req_ready), 32'h0);
    chk("t3_w1_haddr", bus.ahb3_haddr_o, 32'h14);
    chk("t3_w1_htrans", 32'(bus.ahb3_htrans_o), 32'h2);
    chk("t3_w1_rsp", 32'(bus.rsp_valid), 32'h0);
    cyc();
    chk("t3_w2_ready", 32'(bus.req_ready), 32'h0);
    chk("t3_w2_haddr", bus.ahb3_haddr_o, 32'h14);
    chk("t3_w2_rsp", 32'(bus.rsp_valid), 32'h0);
    cyc();
    slv(1'b1, 1'b0, 32'hB10); #1;
    chk("t3_rel_haddr", bus.ahb3_haddr_o, 32'h14);
    chk("t3_rel_ready", 32'(bus.req_ready), 32'h1);
    chk("t3_rel_rsp", 32'(bus.rsp_valid), 32'h0);
    cyc();
    slv(1'b1, 1'b0, 32'hB14); #1;
    chk("t3_rsp0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_rsp0_data", bus.rsp_data, 32'hB10);
    chk("t3_htrans_idle", 32'(bus.ahb3_htrans_o), 32'h0);
    cyc();
    slv(1'b1, 1'b0, 32'h0); #1;
    chk("t3_rsp1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t3_rsp1_data", bus.rsp_data, 32'hB14);
    cyc();
    chk("t3_rsp_done", 32'(bus.rsp_valid), 32'h0);

    // ERROR on write 0x20 with write 0x24 pending
    req(1'b1, 32'h20, 1'b1, 32'h11); #1;
    cyc();
    req(1'b1, 32'h24, 1'b1, 32'h22); #1;
    chk("t4_haddr_a", bus.ahb3_haddr_o, 32'h20);
    cyc();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    slv(1'b0, 1'b1, 32'h0); #1;
    chk("t4_err1_ready", 32'(bus.req_ready), 32'h0);
    chk("t4_err1_rsp", 32'(bus.rsp_valid), 32'h0);
    cyc();
    slv(1'b1, 1'b1, 32'h0); #1;
    chk("t4_err2_htrans", 32'(bus.ahb3_htrans_o), 32'h0);
    chk("t4_err2_hsel", 32'(bus.ahb3_hsel_o), 32'h0);
    chk("t4_err2_rsp", 32'(bus.rsp_valid), 32'h0);
    chk("t4_err2_hwdata", bus.ahb3_hwdata_o, 32'h11);
    cyc();
    slv(1'b1, 1'b0, 32'h0); #1;
    chk("t4_rsp0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t4_rsp0_err", 32'(bus.rsp_err), 32'h1);
    chk("t4_rsp0_data", bus.rsp_data, 32'h0);
    chk("t4_flush_htrans", 32'(bus.ahb3_htrans_o), 32'h0);
    chk("t4_no24_a", 32'(bus.ahb3_htrans_o == 2'b10 && bus.ahb3_haddr_o == 32'h24), 32'h0);
    chk("t4_no_cancel_wdata", bus.ahb3_hwdata_o, 32'h11);
    cyc();
    chk("t4_rsp1_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t4_rsp1_err", 32'(bus.rsp_err), 32'h1);
    chk("t4_rsp1_data", bus.rsp_data, 32'h0);
    chk("t4_no24_b", 32'(bus.ahb3_htrans_o == 2'b10 && bus.ahb3_haddr_o == 32'h24), 32'h0);
    cyc();
    chk("t4_rsp_done", 32'(bus.rsp_valid), 32'h0);
    chk("t4_ready_after", 32'(bus.req_ready), 32'h1);

    // Timeout (TIMEOUT=4) with hready stuck low on read 0x30
    req(1'b1, 32'h30, 1'b0, 32'h0); #1;
    cyc();
    req(1'b0, 32'h0, 1'b0, 32'h0); #1;
    chk("t5_haddr", bus.ahb3_haddr_o, 32'h30);
    chk("t5_htrans", 32'(bus.ahb3_htrans_o), 32'h2);
    cyc();
    slv(1'b0, 1'b0, 32'h0);
    for (int w = 1; w <= 4; w++) begin
      #1;
      chk($sformatf("t5_wait%0d_rsp", w), 32'(bus.rsp_valid), 32'h0);
      cyc();
    end
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t5_rsp_err", 32'(bus.rsp_err), 32'h1);
    chk("t5_rsp_data", bus.rsp_data, 32'h0);
    chk("t5_htrans_idle", 32'(bus.ahb3_htrans_o), 32'h0);
    chk("t5_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    chk("t5_rsp_done", 32'(bus.rsp_valid), 32'h0);
    chk("t5_ready_idle", 32'(bus.req_ready), 32'h1);
    slv(1'b1, 1'b0, 32'h0);
    cyc();

    // Reset asserted during a wait state with both slots occupied
    req(1'b1, 32'h43, 1'b0, 32'h55AA); #1;
    cyc();
    req(1'b1, 32'h44, 1'b0, 32'h66BB); #1;
    chk("t6_haddr_aligned", bus.ahb3_haddr_o, 32'h40);
    cyc();
    req(1'b0, 32'h0, 1'b0, 32'h0);
    slv(1'b0, 1'b0, 32'h0); #1;
    chk("t6_hwdata", bus.ahb3_hwdata_o, 32'h55AA);
    cyc();
    rst = 1'b0; #1;
    chk("t6_ready_in_rst", 32'(bus.req_ready), 32'h0);
    cyc();
    chk("t6_htrans", 32'(bus.ahb3_htrans_o), 32'h0);
    chk("t6_hsel", 32'(bus.ahb3_hsel_o), 32'h0);
    chk("t6_hmastlock", 32'(bus.ahb3_hmastlock_o), 32'h0);
    chk("t6_hwrite", 32'(bus.ahb3_hwrite_o), 32'h0);
    chk("t6_haddr", bus.ahb3_haddr_o, 32'h0);
    chk("t6_hwdata_rst", bus.ahb3_hwdata_o, 32'h0);
    chk("t6_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t6_rsp_data", bus.rsp_data, 32'h0);
    chk("t6_rsp_err", 32'(bus.rsp_err), 32'h0);
    rst = 1'b1;
    slv(1'b1, 1'b0, 32'h0);
    cyc();
    chk("t6_no_rsp_a", 32'(bus.rsp_valid), 32'h0);
    chk("t6_idle_htrans", 32'(bus.ahb3_htrans_o), 32'h0);
    cyc();
    chk("t6_no_rsp_b", 32'(bus.rsp_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
